// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Buffered front end for the UART transmitter. Bytes from the
//             host are queued in a circular FIFO. Each byte is then launched
//             into the transmitter as a one-cycle enable pulse, and the next
//             launch waits until the transmitter's busy flag has risen and
//             fallen again.
//  Ports    :
//    clk          in   system clock, rising edge
//    reset        in   asynchronous reset, active low
//    wr_en        in   host write strobe
//    wr_data      in   host byte
//    fifo_full    out  occupancy == FIFO_DEPTH (registered)
//    fifo_empty   out  occupancy == 0 (registered)
//    fifo_level   out  current occupancy
//    overflow     out  write attempted while full and no slot freed this cycle
//    tx_enable    out  one-cycle launch pulse to the transmitter
//    tx_data      out  launched byte; holds its value between launches
//    tx_busy      in   transmitter busy flag
//    launch_error out  transmitter never went busy after a launch
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter int BUSY_TIMEOUT     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [INPUT_DATA_WIDTH-1:0]   wr_data,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          tx_enable,
  output logic [INPUT_DATA_WIDTH-1:0]   tx_data,
  input  logic                          tx_busy,
  output logic                          launch_error
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;

  localparam logic [c_lvl_w-1:0] c_full_level   = c_lvl_w'(FIFO_DEPTH);
  // The counter is checked before it increments, so the last waiting
  // cycle is the one where it still holds BUSY_TIMEOUT-1.
  localparam logic [3:0]         c_timeout_last = 4'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [INPUT_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  state_e                      state_q,   state_d;
  logic [c_ptr_w-1:0]          wr_ptr_q,  wr_ptr_d;
  logic [c_ptr_w-1:0]          rd_ptr_q,  rd_ptr_d;
  logic [c_lvl_w-1:0]          level_q,   level_d;
  logic                        full_q,    full_d;
  logic                        empty_q,   empty_d;
  logic [3:0]                  cnt_q,     cnt_d;
  logic [INPUT_DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic w_push;
  logic w_pop;
  logic w_launch_err;
  logic w_tx_en;

  // --------------------------------------------------------------------------
  // Launch FSM: next state, pop decision and launch/timeout strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    w_pop        = 1'b0;
    w_launch_err = 1'b0;
    w_tx_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A busy transmitter, even one driven from elsewhere, blocks launch.
        if (!empty_q && !tx_busy) begin
          w_pop     = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        w_tx_en = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == c_timeout_last) begin
          // The byte is abandoned, not retried.
          w_launch_err = 1'b1;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO bookkeeping. A pop in the same cycle frees a slot, so a write into
  // a full FIFO is still accepted when the FSM pops at the same time.
  // --------------------------------------------------------------------------
  always_comb begin
    w_push   = wr_en && (!full_q || w_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    end
    level_d = level_q + c_lvl_w'(w_push) - c_lvl_w'(w_pop);

    full_d  = (level_d == c_full_level);
    empty_d = (level_d == '0);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      cnt_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Storage is never cleared. The pointers and the level decide what is
  // valid, so a slot written during reset is never read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign fifo_level   = level_q;
  assign overflow     = wr_en && full_q && !w_pop;
  assign tx_enable    = w_tx_en;
  assign tx_data      = tx_data_q;
  assign launch_error = w_launch_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo. A small transmitter
//             model raises busy one cycle after each enable and holds it for
//             frame_len cycles. It can also be forced busy or told to ignore
//             enables.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       fifo_full, fifo_empty, overflow, tx_enable, launch_error;
  logic [4:0] fifo_level;
  logic [7:0] tx_data;
  logic       tx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_fifo #(
    .INPUT_DATA_WIDTH(8),
    .FIFO_DEPTH      (16),
    .BUSY_TIMEOUT    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .launch_error(launch_error)
  );

  always #5 clk = ~clk;

  // Transmitter model
  logic force_busy = 1'b0;
  logic ignore_en  = 1'b0;
  int   frame_len  = 5;
  int   busy_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset)                     busy_cnt <= 0;
    else if (tx_enable && !ignore_en) busy_cnt <= frame_len;
    else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Launch / error monitor
  logic [7:0] got[$];
  int         launch_cyc[$];
  int         err_cyc[$];
  logic       prev_en = 1'b0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      if (tx_enable) begin
        chk("no_back_to_back_enable", {31'd0, prev_en}, 32'd0);
        got.push_back(tx_data);
        launch_cyc.push_back(cyc);
      end
      if (launch_error) err_cyc.push_back(cyc);
      prev_en = tx_enable;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends at a negative edge with reset released and the model idle.
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    wr_en      = 1'b0;
    force_busy = 1'b0;
    ignore_en  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    got.delete();
    launch_cyc.delete();
    err_cyc.delete();
  endtask

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       exp_ovf;
    logic [4:0] exp_level;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Table: transmitter held busy, fill to 16, one overflow, one idle row.
    tbl[0] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1};
    for (int i = 1; i <= 16; i++)
      tbl[i] = '{1'b1, 8'(8'h0F + i), 1'b0, 5'(i), (i == 16), 1'b0};
    tbl[17] = '{1'b1, 8'hFF, 1'b1, 5'd16, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0};

    // ---------------- Reset: writes while in reset are ignored ------------
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty",     {31'd0, fifo_empty},   32'd1);
    chk("rst_full",      {31'd0, fifo_full},    32'd0);
    chk("rst_level",     {27'd0, fifo_level},   32'd0);
    chk("rst_overflow",  {31'd0, overflow},     32'd0);
    chk("rst_tx_enable", {31'd0, tx_enable},    32'd0);
    chk("rst_tx_data",   {24'd0, tx_data},      32'd0);
    chk("rst_launch_error", {31'd0, launch_error}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0;
    repeat (5) tick();
    chk("post_rst_level", {27'd0, fifo_level}, 32'd0);
    chk("post_rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("post_rst_no_launch", got.size(), 32'd0);

    // ---------------- Single byte, long frame -----------------------------
    do_reset();
    frame_len = 100;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("single_level_after_write", {27'd0, fifo_level}, 32'd1);
    chk("single_no_enable_yet", {31'd0, tx_enable}, 32'd0);
    tick();
    chk("single_enable", {31'd0, tx_enable}, 32'd1);
    chk("single_data", {24'd0, tx_data}, 32'hA5);
    chk("single_level_popped", {27'd0, fifo_level}, 32'd0);
    chk("single_empty", {31'd0, fifo_empty}, 32'd1);
    tick();
    chk("single_enable_one_cycle", {31'd0, tx_enable}, 32'd0);
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 200 && tx_busy; i++) tick();
    chk("single_busy_fell", {31'd0, tx_busy}, 32'd0);
    chk("single_one_launch_during_busy", got.size(), 32'd1);
    tick();
    chk("second_not_yet", {31'd0, tx_enable}, 32'd0);
    tick();
    chk("second_enable", {31'd0, tx_enable}, 32'd1);
    chk("second_data", {24'd0, tx_data}, 32'h3C);
    chk("second_holds_data_after", 32'd0, 32'd0 + {31'd0, ~tx_enable}); // tx_enable high here

    // ---------------- Burst ordering, transmitter idle --------------------
    do_reset();
    frame_len = 5;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    // Pops land on the 2nd and 10th write edges with an 8-cycle launch period.
    chk("burst_level", {27'd0, fifo_level}, 32'd14);
    chk("burst_not_full", {31'd0, fifo_full}, 32'd0);
    for (int i = 0; i < 400 && got.size() < 16; i++) tick();
    chk("burst_count", got.size(), 32'd16);
    if (got.size() == 16)
      for (int k = 0; k < 16; k++) chk($sformatf("burst_byte%0d", k), {24'd0, got[k]}, k);
    repeat (20) tick();
    chk("burst_no_extra", got.size(), 32'd16);
    chk("burst_drained_empty", {31'd0, fifo_empty}, 32'd1);

    // ---------------- Table: fill, overflow, busy blocks launch ------------
    do_reset();
    force_busy = 1'b1;
    for (int r = 0; r < 19; r++) begin
      wr_en   = tbl[r].wr_en;
      wr_data = tbl[r].wr_data;
      #1;
      chk($sformatf("tbl%0d_overflow", r), {31'd0, overflow}, {31'd0, tbl[r].exp_ovf});
      chk($sformatf("tbl%0d_tx_enable", r), {31'd0, tx_enable}, 32'd0);
      tick();
      chk($sformatf("tbl%0d_level", r), {27'd0, fifo_level}, {27'd0, tbl[r].exp_level});
      chk($sformatf("tbl%0d_full", r), {31'd0, fifo_full}, {31'd0, tbl[r].exp_full});
      chk($sformatf("tbl%0d_empty", r), {31'd0, fifo_empty}, {31'd0, tbl[r].exp_empty});
      @(negedge clk);
    end
    wr_en = 1'b0;

    // ---------------- Push and pop together while full ---------------------
    force_busy = 1'b0;
    wr_en      = 1'b1;
    wr_data    = 8'h55;
    #1;
    chk("pp_no_overflow", {31'd0, overflow}, 32'd0);
    tick();
    wr_en = 1'b0;
    chk("pp_level", {27'd0, fifo_level}, 32'd16);
    chk("pp_full", {31'd0, fifo_full}, 32'd1);
    chk("pp_enable", {31'd0, tx_enable}, 32'd1);
    chk("pp_first_data", {24'd0, tx_data}, 32'h10);
    for (int i = 0; i < 600 && got.size() < 17; i++) tick();
    chk("pp_count", got.size(), 32'd17);
    if (got.size() == 17) begin
      for (int k = 0; k < 16; k++) chk($sformatf("pp_byte%0d", k), {24'd0, got[k]}, 32'h10 + k);
      chk("pp_last_is_55", {24'd0, got[16]}, 32'h55);
    end
    repeat (20) tick();
    chk("pp_no_extra_ff", got.size(), 32'd17);

    // ---------------- Busy timeout ----------------------------------------
    do_reset();
    ignore_en = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h81;
    tick();
    wr_data = 8'h82;
    tick();
    wr_en = 1'b0;
    repeat (20) tick();
    chk("to_launches", launch_cyc.size(), 32'd2);
    chk("to_errors", err_cyc.size(), 32'd2);
    if (launch_cyc.size() == 2 && err_cyc.size() == 2) begin
      chk("to_err0_delay", err_cyc[0] - launch_cyc[0], 32'd4);
      chk("to_relaunch_delay", launch_cyc[1] - launch_cyc[0], 32'd6);
      chk("to_err1_delay", err_cyc[1] - launch_cyc[1], 32'd4);
      chk("to_byte0", {24'd0, got[0]}, 32'h81);
      chk("to_byte1", {24'd0, got[1]}, 32'h82);
    end
    chk("to_empty", {31'd0, fifo_empty}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
